// File: rtl/msdf_pkg.sv
// Shared definitions for the MSDF serial-to-binary sink: digit encodings,
// FSM state encoding and a constant-evaluable clog2.
package msdf_pkg;

   localparam logic [1:0] DIGIT_POS = 2'b10;
   localparam logic [1:0] DIGIT_NEG = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/msdf_otf_reg.sv
// On-the-fly conversion register pair: Q and QM = Q - 1, extended one digit
// per shift so the two's-complement value never needs a carry chain.
module msdf_otf_reg
   import msdf_pkg::*;
#(
   parameter int unsigned W = 65
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_clr,
   input  logic         i_init,
   input  logic         i_shift,
   input  logic [1:0]   i_digit,
   output logic [W-1:0] o_q_nxt
);

   logic [W-1:0] r_q;
   logic [W-1:0] r_qm;
   logic [W-1:0] w_bq;
   logic [W-1:0] w_bqm;
   logic [W-1:0] w_q_sh;
   logic [W-1:0] w_qm_sh;

   // A frame's first digit shifts into the empty pair (Q = 0, QM = -1).
   always_comb begin
      w_bq  = i_init ? '0 : r_q;
      w_bqm = i_init ? '1 : r_qm;
      case (i_digit)
         DIGIT_POS: begin
            w_q_sh  = {w_bq[W-2:0], 1'b1};
            w_qm_sh = {w_bq[W-2:0], 1'b0};
         end
         DIGIT_NEG: begin
            w_q_sh  = {w_bqm[W-2:0], 1'b1};
            w_qm_sh = {w_bqm[W-2:0], 1'b0};
         end
         default: begin
            w_q_sh  = {w_bq[W-2:0], 1'b0};
            w_qm_sh = {w_bqm[W-2:0], 1'b1};
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_q  <= '0;
         r_qm <= '1;
      end else if (i_clr) begin
         r_q  <= '0;
         r_qm <= '1;
      end else if (i_shift) begin
         r_q  <= w_q_sh;
         r_qm <= w_qm_sh;
      end
   end

   assign o_q_nxt = i_shift ? w_q_sh : r_q;

endmodule

// File: rtl/msdf_serial_to_binary.sv
// MSDF signed-digit stream sink: accumulates one frame MSD-first and presents
// the two's-complement word, digit count and point position on a valid/ready port.
module msdf_serial_to_binary
   import msdf_pkg::*;
#(
   parameter  int unsigned ACCURATE_MAX = 64,
   localparam int unsigned W            = ACCURATE_MAX + 1,
   localparam int unsigned CW           = clog2(ACCURATE_MAX + 1)
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_mbus_wen,
   input  logic [1:0]    i_mbus_wdata,
   input  logic          i_mbus_wpoint,
   input  logic          i_mbus_wvalid,
   input  logic          i_mbus_wlast,
   output logic          o_mbus_wstop,
   output logic          o_mbus_wclr,
   input  logic          i_clr,
   output logic          o_res_valid,
   input  logic          i_res_ready,
   output logic [W-1:0]  o_res_data,
   output logic [CW-1:0] o_res_digits,
   output logic [CW-1:0] o_res_point,
   output logic          o_res_ovf
);

   state_t        r_state;
   state_t        w_state_nxt;

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_pt;
   logic          r_pt_seen;
   logic          r_ovf;
   logic [W-1:0]  r_res_data;
   logic [CW-1:0] r_res_digits;
   logic [CW-1:0] r_res_point;
   logic          r_res_ovf;
   logic          r_wclr;

   logic          w_acc;
   logic          w_first;
   logic          w_ign;
   logic          w_shift;
   logic          w_close;
   logic          w_pt_take;
   logic [CW-1:0] w_cnt_base;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_pt_nxt;
   logic          w_pt_seen_nxt;
   logic          w_ovf_nxt;
   logic [W-1:0]  w_q_nxt;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // A new frame may open while DONE hands off, so DONE can loop to ACC or DONE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_acc) w_state_nxt = i_mbus_wlast ? ST_DONE : ST_ACC;
         ST_ACC:  if (w_acc && i_mbus_wlast) w_state_nxt = ST_DONE;
         ST_DONE: if (i_res_ready) begin
            if (w_acc) w_state_nxt = i_mbus_wlast ? ST_DONE : ST_ACC;
            else       w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (i_clr) w_state_nxt = ST_IDLE;
   end

   always_comb begin
      o_res_valid  = 1'b0;
      o_mbus_wstop = 1'b0;
      if (r_state == ST_DONE) begin
         o_res_valid  = 1'b1;
         o_mbus_wstop = ~i_res_ready;
      end
   end

   // Per-digit bookkeeping; the first digit of a frame restarts from zero.
   always_comb begin
      w_acc         = i_mbus_wen & i_mbus_wvalid & ~o_mbus_wstop;
      w_first       = w_acc & (r_state != ST_ACC);
      w_close       = w_acc & i_mbus_wlast;
      w_cnt_base    = w_first ? '0 : r_cnt;
      w_ign         = w_acc & (w_cnt_base == CW'(ACCURATE_MAX));
      w_shift       = w_acc & ~w_ign;
      w_cnt_nxt     = w_shift ? CW'(w_cnt_base + CW'(1)) : w_cnt_base;
      w_ovf_nxt     = (~w_first & r_ovf) | w_ign;
      w_pt_take     = w_acc & i_mbus_wpoint & (w_first | ~r_pt_seen);
      w_pt_seen_nxt = (~w_first & r_pt_seen) | w_pt_take;
      w_pt_nxt      = w_pt_take ? w_cnt_base : (w_first ? '0 : r_pt);
   end

   msdf_otf_reg #(.W(W)) u_otf (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_clr   (i_clr),
      .i_init  (w_first),
      .i_shift (w_shift),
      .i_digit (i_mbus_wdata),
      .o_q_nxt (w_q_nxt)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt     <= '0;
         r_pt      <= '0;
         r_pt_seen <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (i_clr) begin
         r_cnt     <= '0;
         r_pt      <= '0;
         r_pt_seen <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (w_acc) begin
         r_cnt     <= w_cnt_nxt;
         r_pt      <= w_pt_nxt;
         r_pt_seen <= w_pt_seen_nxt;
         r_ovf     <= w_ovf_nxt;
      end
   end

   // Result snapshot taken on the frame-closing edge, including that digit.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_res_data   <= '0;
         r_res_digits <= '0;
         r_res_point  <= '0;
         r_res_ovf    <= 1'b0;
      end else if (i_clr) begin
         r_res_data   <= '0;
         r_res_digits <= '0;
         r_res_point  <= '0;
         r_res_ovf    <= 1'b0;
      end else if (w_close) begin
         r_res_data   <= w_q_nxt;
         r_res_digits <= w_cnt_nxt;
         r_res_point  <= w_pt_seen_nxt ? w_pt_nxt : w_cnt_nxt;
         r_res_ovf    <= w_ovf_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_wclr <= 1'b0;
      else         r_wclr <= i_clr;
   end

   assign o_mbus_wclr  = r_wclr;
   assign o_res_data   = r_res_data;
   assign o_res_digits = r_res_digits;
   assign o_res_point  = r_res_point;
   assign o_res_ovf    = r_res_ovf;

endmodule

// File: tb/tb_msdf_serial_to_binary.sv
// Self-checking bench for msdf_serial_to_binary with ACCURATE_MAX = 8:
// fixed vectors, flow-control / clear / reset sequences and random frames.
module tb_msdf_serial_to_binary;

   localparam int MAXD = 8;

   logic       i_clk = 1'b0;
   logic       i_rstn = 1'b0;
   logic       i_mbus_wen = 1'b0;
   logic [1:0] i_mbus_wdata = 2'b00;
   logic       i_mbus_wpoint = 1'b0;
   logic       i_mbus_wvalid = 1'b0;
   logic       i_mbus_wlast = 1'b0;
   logic       o_mbus_wstop;
   logic       o_mbus_wclr;
   logic       i_clr = 1'b0;
   logic       o_res_valid;
   logic       i_res_ready = 1'b0;
   logic [8:0] o_res_data;
   logic [3:0] o_res_digits;
   logic [3:0] o_res_point;
   logic       o_res_ovf;

   int n_err = 0;
   int n_chk = 0;

   msdf_serial_to_binary #(.ACCURATE_MAX(8)) dut (
      .i_clk         (i_clk),
      .i_rstn        (i_rstn),
      .i_mbus_wen    (i_mbus_wen),
      .i_mbus_wdata  (i_mbus_wdata),
      .i_mbus_wpoint (i_mbus_wpoint),
      .i_mbus_wvalid (i_mbus_wvalid),
      .i_mbus_wlast  (i_mbus_wlast),
      .o_mbus_wstop  (o_mbus_wstop),
      .o_mbus_wclr   (o_mbus_wclr),
      .i_clr         (i_clr),
      .o_res_valid   (o_res_valid),
      .i_res_ready   (i_res_ready),
      .o_res_data    (o_res_data),
      .o_res_digits  (o_res_digits),
      .o_res_point   (o_res_point),
      .o_res_ovf     (o_res_ovf)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      string      dig;
      logic [15:0] m;
      logic [8:0] d;
      logic [3:0] nd;
      logic [3:0] np;
      logic       ov;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] code(input string c);
      case (c)
         "+":     return 2'b10;
         "-":     return 2'b01;
         "x":     return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic int dval(input string c);
      if (c == "+") return 1;
      if (c == "-") return -1;
      return 0;
   endfunction

   // Reference: value of the first MAXD digits as a signed integer, point = index of first flag.
   task automatic model(input string s, input logic [15:0] m, output logic [8:0] d,
                        output logic [3:0] nd, output logic [3:0] np, output logic ov);
      int v;
      int n;
      int k;
      int p;
      v = 0;
      n = s.len();
      k = (n > MAXD) ? MAXD : n;
      p = -1;
      for (int i = 0; i < k; i++) v = v * 2 + dval(s.substr(i, i));
      for (int i = 0; i < n; i++) if (m[i] && p < 0) p = i;
      d  = 9'(v);
      nd = 4'(k);
      np = (p < 0) ? 4'(k) : 4'((p > MAXD) ? MAXD : p);
      ov = (n > MAXD);
   endtask

   task automatic clear_in();
      i_mbus_wen    = 1'b0;
      i_mbus_wvalid = 1'b0;
      i_mbus_wlast  = 1'b0;
      i_mbus_wpoint = 1'b0;
      i_mbus_wdata  = 2'b00;
   endtask

   task automatic send_digit(input logic [1:0] d, input logic pt, input logic last);
      int waitc;
      waitc = 0;
      i_mbus_wen    = 1'b1;
      i_mbus_wvalid = 1'b1;
      i_mbus_wdata  = d;
      i_mbus_wpoint = pt;
      i_mbus_wlast  = last;
      @(negedge i_clk);
      while (o_mbus_wstop && waitc < 50) begin
         waitc++;
         @(negedge i_clk);
      end
      if (o_mbus_wstop) begin
         n_chk++;
         n_err++;
         $display("FAIL accept_timeout: wstop stuck at 1, required 0");
      end
      @(posedge i_clk);
      #1;
      clear_in();
      i_res_ready = 1'b0;
   endtask

   // Idle cycle with only one of wen/wvalid set, so nothing may be consumed.
   task automatic gap();
      i_mbus_wen    = 1'($urandom_range(0, 1));
      i_mbus_wvalid = ~i_mbus_wen;
      i_mbus_wdata  = 2'($urandom_range(0, 3));
      i_mbus_wlast  = 1'($urandom_range(0, 1));
      @(posedge i_clk);
      #1;
      clear_in();
   endtask

   task automatic run_frame(input string s, input logic [15:0] m, input logic [8:0] ed,
                            input logic [3:0] en, input logic [3:0] ep, input logic eo,
                            input int hold);
      int n;
      n = s.len();
      for (int i = 0; i < n; i++) begin
         if (i > 0 && $urandom_range(0, 2) == 0) gap();
         send_digit(code(s.substr(i, i)), m[i], (i == n - 1));
      end
      chk("valid", 32'(o_res_valid), 32'd1);
      chk("data", 32'(o_res_data), 32'(ed));
      chk("digits", 32'(o_res_digits), 32'(en));
      chk("point", 32'(o_res_point), 32'(ep));
      chk("ovf", 32'(o_res_ovf), 32'(eo));
      repeat (hold) begin
         @(posedge i_clk);
         #1;
      end
      if (hold > 0) begin
         chk("hold_wstop", 32'(o_mbus_wstop), 32'd1);
         chk("hold_valid", 32'(o_res_valid), 32'd1);
         chk("hold_data", 32'(o_res_data), 32'(ed));
      end
      i_res_ready = 1'b1;
   endtask

   task automatic drain();
      @(posedge i_clk);
      #1;
      i_res_ready = 1'b0;
      chk("drain_valid", 32'(o_res_valid), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(o_res_valid), 32'd0);
      chk({tag, "_data"}, 32'(o_res_data), 32'd0);
      chk({tag, "_digits"}, 32'(o_res_digits), 32'd0);
      chk({tag, "_point"}, 32'(o_res_point), 32'd0);
      chk({tag, "_ovf"}, 32'(o_res_ovf), 32'd0);
      chk({tag, "_wclr"}, 32'(o_mbus_wclr), 32'd0);
      chk({tag, "_wstop"}, 32'(o_mbus_wstop), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] ed;
      logic [3:0] en;
      logic [3:0] ep;
      logic       eo;
      string      s;
      string      tbl;
      logic [15:0] m;
      int         n;
      int         r;
      int         a;
      int         c;

      vt[0] = '{"+0-+",       16'h0000, 9'd7,    4'd4, 4'd4, 1'b0};
      vt[1] = '{"-+",         16'h0002, 9'h1FF,  4'd2, 4'd1, 1'b0};
      vt[2] = '{"++++++++++", 16'h0000, 9'd255,  4'd8, 4'd8, 1'b1};
      vt[3] = '{"+",          16'h0000, 9'd1,    4'd1, 4'd1, 1'b0};
      vt[4] = '{"---",        16'h0001, 9'h1F9,  4'd3, 4'd0, 1'b0};
      vt[5] = '{"00000000",   16'h0028, 9'd0,    4'd8, 4'd3, 1'b0};
      vt[6] = '{"---------",  16'h0000, 9'h101,  4'd8, 4'd8, 1'b1};
      vt[7] = '{"x+x",        16'h0004, 9'd2,    4'd3, 4'd2, 1'b0};
      vt[8] = '{"+++++++++",  16'h0100, 9'd255,  4'd8, 4'd8, 1'b1};
      vt[9] = '{"-0000000",   16'h0000, 9'h180,  4'd8, 4'd8, 1'b0};

      #2;
      check_reset_outputs("rst");
      #10;
      i_rstn = 1'b1;
      @(posedge i_clk);
      #1;

      // Fixed vectors, chained back to back with varying result stall.
      for (int i = 0; i < 10; i++)
         run_frame(vt[i].dig, vt[i].m, vt[i].d, vt[i].nd, vt[i].np, vt[i].ov, i % 4);
      drain();

      // Backpressure: next digit held while result is stalled for 5 cycles.
      run_frame("++", 16'h0, 9'd3, 4'd2, 4'd2, 1'b0, 0);
      i_res_ready   = 1'b0;
      i_mbus_wen    = 1'b1;
      i_mbus_wvalid = 1'b1;
      i_mbus_wdata  = 2'b10;
      repeat (5) begin
         @(negedge i_clk);
         chk("bp_wstop", 32'(o_mbus_wstop), 32'd1);
      end
      chk("bp_valid", 32'(o_res_valid), 32'd1);
      chk("bp_data", 32'(o_res_data), 32'd3);
      i_res_ready = 1'b1;
      @(posedge i_clk);
      #1;
      clear_in();
      i_res_ready = 1'b0;
      chk("bp_handoff_valid", 32'(o_res_valid), 32'd0);
      send_digit(2'b01, 1'b0, 1'b1);
      chk("bp_next_data", 32'(o_res_data), 32'd1);
      chk("bp_next_digits", 32'(o_res_digits), 32'd2);
      i_res_ready = 1'b1;
      drain();

      // Clear while a result is pending.
      run_frame("+-", 16'h0, 9'd1, 4'd2, 4'd2, 1'b0, 0);
      i_res_ready = 1'b0;
      i_clr = 1'b1;
      @(posedge i_clk);
      #1;
      i_clr = 1'b0;
      chk("clr_done_wclr", 32'(o_mbus_wclr), 32'd1);
      chk("clr_done_valid", 32'(o_res_valid), 32'd0);
      chk("clr_done_data", 32'(o_res_data), 32'd0);
      chk("clr_done_digits", 32'(o_res_digits), 32'd0);
      @(posedge i_clk);
      #1;
      chk("clr_done_wclr_low", 32'(o_mbus_wclr), 32'd0);

      // Clear mid-frame after three digits drops the partial frame.
      for (int i = 0; i < 3; i++) send_digit(2'b10, 1'b0, 1'b0);
      i_clr = 1'b1;
      @(posedge i_clk);
      #1;
      i_clr = 1'b0;
      chk("clr_mid_wclr", 32'(o_mbus_wclr), 32'd1);
      chk("clr_mid_valid", 32'(o_res_valid), 32'd0);
      @(posedge i_clk);
      #1;
      chk("clr_mid_wclr_low", 32'(o_mbus_wclr), 32'd0);
      run_frame("+", 16'h0, 9'd1, 4'd1, 4'd1, 1'b0, 0);
      drain();

      // Asynchronous reset while DONE.
      run_frame("-+", 16'h0002, 9'h1FF, 4'd2, 4'd1, 1'b0, 0);
      i_res_ready = 1'b0;
      #2;
      i_rstn = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      #10;
      i_rstn = 1'b1;
      @(posedge i_clk);
      #1;

      // Random frames against the reference model.
      tbl = "+-0x";
      for (int f = 0; f < 30; f++) begin
         n = $urandom_range(1, 11);
         s = "";
         for (int j = 0; j < n; j++) begin
            c = $urandom_range(0, 3);
            s = {s, tbl.substr(c, c)};
         end
         m = 16'h0;
         r = $urandom_range(0, 2);
         if (r > 0) begin a = $urandom_range(0, n - 1); m[a] = 1'b1; end
         if (r == 2) begin a = $urandom_range(0, n - 1); m[a] = 1'b1; end
         model(s, m, ed, en, ep, eo);
         run_frame(s, m, ed, en, ep, eo, $urandom_range(0, 3));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
